// File: rtl/ram1r1w_fifo_ctrl.sv
// First-word-fall-through FIFO built around a RAM whose read port is registered.
// The head word is prefetched one cycle ahead, and a bypass register covers same-cycle write/read collisions.

module ram1r1w #(
  parameter int WIDTH    = 32,
  parameter int LG_DEPTH = 4
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [LG_DEPTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [LG_DEPTH-1:0] rd_addr,
  output logic [WIDTH-1:0]    rd_data
);
  localparam int DEPTH = 1 << LG_DEPTH;

  logic [WIDTH-1:0] mem [DEPTH];

  // A read and a write to the same address in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

module ram1r1w_fifo_ctrl #(
  parameter int WIDTH    = 32,
  parameter int LG_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [WIDTH-1:0]    push_data,
  input  logic                pop,
  output logic [WIDTH-1:0]    head_data,
  output logic                empty,
  output logic                full,
  output logic [LG_DEPTH:0]   count,
  output logic                err_overflow,
  output logic                err_underflow
);
  localparam logic [LG_DEPTH-1:0] PTR_ONE   = 1;
  localparam logic [LG_DEPTH:0]   CNT_ONE   = 1;
  localparam logic [LG_DEPTH:0]   DEPTH_CNT = (LG_DEPTH+1)'(1 << LG_DEPTH);

  logic [LG_DEPTH-1:0] wr_ptr;
  logic [LG_DEPTH-1:0] rd_ptr;
  logic [LG_DEPTH-1:0] rd_addr;
  logic [LG_DEPTH:0]   count_next;
  logic [WIDTH-1:0]    ram_rd_data;
  logic [WIDTH-1:0]    bypass_q;
  logic                bypass_sel;
  logic                push_acc;
  logic                pop_acc;
  logic                collide;

  assign push_acc = push & ~full;
  assign pop_acc  = pop & ~empty;
  // Read one slot ahead on a pop so the next head is on rd_data right after the pop.
  assign rd_addr  = pop_acc ? rd_ptr + PTR_ONE : rd_ptr;
  assign collide  = push_acc && (wr_ptr == rd_addr);

  always_comb begin
    count_next = count;
    if (push_acc && !pop_acc)      count_next = count + CNT_ONE;
    else if (pop_acc && !push_acc) count_next = count - CNT_ONE;
  end

  ram1r1w #(
    .WIDTH    (WIDTH),
    .LG_DEPTH (LG_DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push_acc & ~reset),
    .wr_addr (wr_ptr),
    .wr_data (push_data),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      empty         <= 1'b1;
      full          <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      bypass_sel    <= 1'b0;
      bypass_q      <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_acc)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == DEPTH_CNT);
      if (push && full)  err_overflow  <= 1'b1;
      if (pop && empty)  err_underflow <= 1'b1;
      // The RAM returns stale data on a collision, so the written word is held for one cycle.
      bypass_sel <= collide;
      if (collide) bypass_q <= push_data;
    end
  end

  assign head_data = bypass_sel ? bypass_q : ram_rd_data;
endmodule
